// File: rtl/ram2p_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : ram2p_cfg
//  Brief    : Two-port RAM (one write port, one read port, single clock) with
//             per-lane write enables, read latency of 0/1/2 cycles, a
//             selectable read-during-write policy, and a clear engine that
//             fills every word with INIT_VAL after reset or on request.
//  Revision : 1.0 - initial release
// ============================================================================
module ram2p_cfg #(
    parameter int             DW       = 18,
    parameter int             AW       = 7,
    parameter int             LW       = 9,
    parameter int             RD_LAT   = 1,
    parameter int             BYPASS   = 1,
    parameter logic [DW-1:0]  INIT_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wen,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    input  logic [DW/LW-1:0]     wr_be,
    input  logic                 ren,
    input  logic [AW-1:0]        rd_addr,
    output logic [DW-1:0]        rd_data,
    output logic                 rd_valid,
    input  logic                 init_start,
    output logic                 init_busy
);

    localparam int DEPTH = 2**AW;
    localparam int NL    = DW / LW;

    // Reject configurations the datapath cannot represent.
    generate
        if (RD_LAT < 0 || RD_LAT > 2) begin : g_bad_rd_lat
            $error("ram2p_cfg: RD_LAT must be 0, 1 or 2");
        end
        if ((DW % LW) != 0) begin : g_bad_lane
            $error("ram2p_cfg: DW must be a multiple of LW");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t           state_q;
    logic [AW-1:0]    cnt_q;
    logic             busy_q;

    logic [DW-1:0]    mem_q [DEPTH];

    logic             wr_acc;
    logic             rd_acc;
    logic [DW-1:0]    mem_rd;

    // User traffic is only honoured once the clear engine has finished.
    assign wr_acc    = wen & ~busy_q;
    assign rd_acc    = ren & ~busy_q;
    assign mem_rd    = mem_q[rd_addr];
    assign init_busy = busy_q;

    // Clear engine: sweep every address once, then wait for a new request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (&cnt_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    if (init_start) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Array write: the clear engine owns the port while busy, else lane writes.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[cnt_q] <= INIT_VAL;
        end else if (wr_acc) begin
            for (int i = 0; i < NL; i++) begin
                if (wr_be[i]) begin
                    mem_q[wr_addr][i*LW +: LW] <= wr_data[i*LW +: LW];
                end
            end
        end
    end

    generate
        if (RD_LAT == 0) begin : g_lat0
            // Asynchronous read; a same-cycle write lands on the next edge.
            assign rd_data  = mem_rd;
            assign rd_valid = rd_acc;
        end else begin : g_lat_reg
            logic [DW-1:0] rd_merge;
            logic [DW-1:0] s1_data_q;
            logic          s1_valid_q;

            // Write-first forwarding of enabled lanes on a same-address hit.
            always_comb begin
                rd_merge = mem_rd;
                if (BYPASS != 0 && wr_acc && (wr_addr == rd_addr)) begin
                    for (int i = 0; i < NL; i++) begin
                        if (wr_be[i]) begin
                            rd_merge[i*LW +: LW] = wr_data[i*LW +: LW];
                        end
                    end
                end
            end

            // First output stage: capture on accept, hold otherwise.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_data_q  <= '0;
                    s1_valid_q <= 1'b0;
                end else begin
                    s1_valid_q <= rd_acc;
                    if (rd_acc) begin
                        s1_data_q <= rd_merge;
                    end
                end
            end

            if (RD_LAT == 2) begin : g_lat2
                logic [DW-1:0] s2_data_q;
                logic          s2_valid_q;

                // Second output stage for timing; same hold-on-idle behaviour.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        s2_data_q  <= '0;
                        s2_valid_q <= 1'b0;
                    end else begin
                        s2_valid_q <= s1_valid_q;
                        if (s1_valid_q) begin
                            s2_data_q <= s1_data_q;
                        end
                    end
                end

                assign rd_data  = s2_data_q;
                assign rd_valid = s2_valid_q;
            end else begin : g_lat1
                assign rd_data  = s1_data_q;
                assign rd_valid = s1_valid_q;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ram2p_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram2p_cfg
//  Brief    : Self-checking bench for ram2p_cfg. Four instances share one
//             stimulus stream: RD_LAT=1 write-first, RD_LAT=1 read-first,
//             RD_LAT=2 write-first and RD_LAT=0. A behavioural model queues
//             expected read data at acceptance; a monitor compares outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram2p_cfg;

    localparam int             DW    = 18;
    localparam int             AW    = 3;
    localparam int             LW    = 9;
    localparam int             NL    = 2;
    localparam int             DEPTH = 8;
    localparam logic [DW-1:0]  INIT  = 18'h155;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          wen        = 1'b0;
    logic [AW-1:0] wr_addr    = '0;
    logic [DW-1:0] wr_data    = '0;
    logic [NL-1:0] wr_be      = '0;
    logic          ren        = 1'b0;
    logic [AW-1:0] rd_addr    = '0;
    logic          init_start = 1'b0;

    logic [DW-1:0] d_b1, d_b0, d_l2, d_l0;
    logic          v_b1, v_b0, v_l2, v_l0;
    logic          bz_b1, bz_b0, bz_l2, bz_l0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram2p_cfg #(.DW(DW), .AW(AW), .LW(LW), .RD_LAT(1), .BYPASS(1), .INIT_VAL(INIT)) u_b1 (
        .clk(clk), .rst(rst), .wen(wen), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .ren(ren), .rd_addr(rd_addr), .rd_data(d_b1),
        .rd_valid(v_b1), .init_start(init_start), .init_busy(bz_b1));

    ram2p_cfg #(.DW(DW), .AW(AW), .LW(LW), .RD_LAT(1), .BYPASS(0), .INIT_VAL(INIT)) u_b0 (
        .clk(clk), .rst(rst), .wen(wen), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .ren(ren), .rd_addr(rd_addr), .rd_data(d_b0),
        .rd_valid(v_b0), .init_start(init_start), .init_busy(bz_b0));

    ram2p_cfg #(.DW(DW), .AW(AW), .LW(LW), .RD_LAT(2), .BYPASS(1), .INIT_VAL(INIT)) u_l2 (
        .clk(clk), .rst(rst), .wen(wen), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .ren(ren), .rd_addr(rd_addr), .rd_data(d_l2),
        .rd_valid(v_l2), .init_start(init_start), .init_busy(bz_l2));

    ram2p_cfg #(.DW(DW), .AW(AW), .LW(LW), .RD_LAT(0), .BYPASS(1), .INIT_VAL(INIT)) u_l0 (
        .clk(clk), .rst(rst), .wen(wen), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .ren(ren), .rd_addr(rd_addr), .rd_data(d_l0),
        .rd_valid(v_l0), .init_start(init_start), .init_busy(bz_l0));

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model, advanced on each rising edge from stable inputs
    // ------------------------------------------------------------------
    logic [DW-1:0] m_mem [DEPTH];
    logic          m_busy = 1'b1;
    logic [AW-1:0] m_cnt  = '0;
    logic          ev1    = 1'b0;
    logic          ev2    = 1'b0;
    logic [DW-1:0] q_b1[$];
    logic [DW-1:0] q_b0[$];
    logic [DW-1:0] q_l2[$];
    logic [DW-1:0] last_b1 = '0;
    logic [DW-1:0] last_b0 = '0;
    logic [DW-1:0] last_l2 = '0;

    always @(posedge clk) begin
        logic [DW-1:0] old_v;
        logic [DW-1:0] new_v;
        logic          acc_r;
        logic          acc_w;
        if (rst) begin
            m_busy = 1'b1;
            m_cnt  = '0;
            ev1    = 1'b0;
            ev2    = 1'b0;
        end else begin
            acc_r = ren && !m_busy;
            acc_w = wen && !m_busy;
            ev2   = ev1;
            ev1   = acc_r;
            if (acc_r) begin
                old_v = m_mem[rd_addr];
                new_v = old_v;
                if (acc_w && wr_addr == rd_addr) begin
                    for (int i = 0; i < NL; i++)
                        if (wr_be[i]) new_v[i*LW +: LW] = wr_data[i*LW +: LW];
                end
                q_b1.push_back(new_v);
                q_l2.push_back(new_v);
                q_b0.push_back(old_v);
            end
            if (m_busy) begin
                m_mem[m_cnt] = INIT;
                if (m_cnt == AW'(DEPTH - 1)) m_busy = 1'b0;
                m_cnt = m_cnt + 1'b1;
            end else begin
                if (acc_w) begin
                    for (int i = 0; i < NL; i++)
                        if (wr_be[i]) m_mem[wr_addr][i*LW +: LW] = wr_data[i*LW +: LW];
                end
                if (init_start) begin
                    m_busy = 1'b1;
                    m_cnt  = '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor on the falling edge, away from the active edge
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        chk1("busy_b1", bz_b1, m_busy);
        chk1("busy_b0", bz_b0, m_busy);
        chk1("busy_l2", bz_l2, m_busy);
        chk1("busy_l0", bz_l0, m_busy);
        if (rst) begin
            last_b1 = '0;
            last_b0 = '0;
            last_l2 = '0;
            q_b1.delete();
            q_b0.delete();
            q_l2.delete();
        end else begin
            if (ev1 && q_b1.size() != 0) last_b1 = q_b1.pop_front();
            if (ev1 && q_b0.size() != 0) last_b0 = q_b0.pop_front();
            if (ev2 && q_l2.size() != 0) last_l2 = q_l2.pop_front();
            chk1("valid_b1", v_b1, ev1);
            chk ("data_b1",  d_b1, last_b1);
            chk1("valid_b0", v_b0, ev1);
            chk ("data_b0",  d_b0, last_b0);
            chk1("valid_l2", v_l2, ev2);
            chk ("data_l2",  d_l2, last_l2);
            chk1("valid_l0", v_l0, ren && !m_busy);
            if (!m_busy) chk("data_l0", d_l0, m_mem[rd_addr]);
        end
    end

    // Advance n cycles; inputs change 1 time unit after the rising edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset, then the power-on clear runs for DEPTH cycles.
        cyc(3);
        rst = 1'b0;
        cyc(10);

        // Every word holds INIT after the clear.
        for (int i = 0; i < DEPTH; i++) begin
            ren = 1'b1; rd_addr = AW'(i); cyc(1);
        end
        ren = 1'b0; cyc(3);

        // Lane write: full write, then clear only lane 0.
        wen = 1'b1; wr_addr = 3'd2; wr_data = 18'h3FFFF; wr_be = 2'b11; cyc(1);
        wr_data = 18'h00000; wr_be = 2'b01; cyc(1);
        wen = 1'b0; ren = 1'b1; rd_addr = 3'd2; cyc(1);
        ren = 1'b0; cyc(3);

        // Collision at address 5 with only the upper lane enabled.
        wen = 1'b1; wr_addr = 3'd5; wr_data = 18'h00AAA; wr_be = 2'b11; cyc(1);
        wr_data = 18'h15555; wr_be = 2'b10; ren = 1'b1; rd_addr = 3'd5; cyc(1);
        wen = 1'b0; cyc(1);
        ren = 1'b0; cyc(3);

        // Back-to-back reads through the pipeline.
        for (int i = 0; i < 4; i++) begin
            ren = 1'b1; rd_addr = AW'(i); cyc(1);
        end
        ren = 1'b0; cyc(4);

        // Clear request with a read accepted in the same cycle, then
        // write/read attempts while busy.
        ren = 1'b1; rd_addr = 3'd2; init_start = 1'b1; cyc(1);
        init_start = 1'b0;
        wen = 1'b1; wr_addr = 3'd1; wr_data = 18'h12345; wr_be = 2'b11; rd_addr = 3'd1; cyc(1);
        wen = 1'b0; cyc(3);
        ren = 1'b0; cyc(6);
        ren = 1'b1; rd_addr = 3'd1; cyc(1);
        ren = 1'b0; cyc(3);

        // Reset pulse in the middle of a clear restarts it from scratch.
        init_start = 1'b1; cyc(1);
        init_start = 1'b0; cyc(4);
        rst = 1'b1; cyc(1);
        rst = 1'b0; cyc(12);

        // Fill with random data, then sweep the address with ren low.
        for (int i = 0; i < DEPTH; i++) begin
            wen = 1'b1; wr_addr = AW'(i); wr_data = DW'($urandom); wr_be = 2'b11; cyc(1);
        end
        wen = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rd_addr = AW'(i); cyc(1);
        end

        // Same-address write and read: old value now, new value next cycle.
        wen = 1'b1; wr_addr = 3'd3; wr_data = 18'h2ABCD; wr_be = 2'b11;
        ren = 1'b1; rd_addr = 3'd3; cyc(1);
        wen = 1'b0; cyc(1);
        ren = 1'b0; cyc(2);

        // A write with no lanes enabled changes nothing.
        wen = 1'b1; wr_addr = 3'd4; wr_data = 18'h3FFFF; wr_be = 2'b00; cyc(1);
        wen = 1'b0; ren = 1'b1; rd_addr = 3'd4; cyc(1);
        ren = 1'b0; cyc(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
